// File: rtl/debounce_pkg.sv
// Shared definitions for the shared-timer debounce controller.
//   - 3-bit per-channel state codes
//   - idx_w(): width of a channel index (never less than 1)
package debounce_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ1   = 3'd1;
  localparam logic [2:0] WAIT_1 = 3'd2;
  localparam logic [2:0] PULSE  = 3'd3;
  localparam logic [2:0] HELD   = 3'd4;
  localparam logic [2:0] REQ0   = 3'd5;
  localparam logic [2:0] WAIT_0 = 3'd6;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_debounce_sched_arb.sv
// Round-robin arbiter, purely combinational.
//   req       : per-channel request vector
//   en        : arbitration enable (timer free)
//   ptr       : channel with highest priority this cycle
//   gnt_valid : a request was granted
//   gnt_idx   : granted channel (first requester at or after ptr, with wrap)
module rr_arbiter
  import debounce_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  // Scan from the farthest offset down to ptr so the closest requester
  // is the last one written and therefore wins.
  always_comb begin
    int j;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    if (en) begin
      for (int off = N - 1; off >= 0; off--) begin
        j = (int'(ptr) + off) % N;
        if (req[j]) begin
          gnt_valid = 1'b1;
          gnt_idx   = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/shared_debounce_sched.sv
// Debounce controller for NCH push buttons sharing one debounce timer.
//   clk, rst   : clock, synchronous active-high reset
//   sw_in      : raw asynchronous button levels (1 = pressed)
//   sw_out     : one-cycle pulse per debounced press (at most one bit high)
//   evt_valid  : any sw_out bit high
//   evt_id     : index of the pulsing channel, 0 otherwise
//   busy       : the shared timer is owned by a channel
module shared_debounce_sched
  import debounce_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int TBITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          sw_in,
  output logic [NCH-1:0]          sw_out,
  output logic                    evt_valid,
  output logic [$clog2(NCH)-1:0]  evt_id,
  output logic                    busy
);

  localparam int IW = idx_w(NCH);

  logic [NCH-1:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NCH-1:0][2:0] state_q, state_d;
  logic                owner_vld_q, owner_vld_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [TBITS-1:0]    cnt_q, cnt_d;

  logic [NCH-1:0]      req;
  logic                gnt_valid;
  logic [IW-1:0]       gnt_idx;
  logic                expire;

  always_comb begin
    for (int i = 0; i < NCH; i++)
      req[i] = (state_q[i] == REQ1) || (state_q[i] == REQ0);
  end

  // Arbitration only happens while the timer is free, so a grant and an
  // expiry can never coincide.
  rr_arbiter #(.N(NCH), .IW(IW)) u_arb (
    .req       (req),
    .en        (!owner_vld_q),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign expire = owner_vld_q && (cnt_q == {TBITS{1'b1}});

  always_comb begin
    sync1_d     = sw_in;
    sync2_d     = sync1_q;
    state_d     = state_q;
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;

    for (int i = 0; i < NCH; i++) begin
      unique case (state_q[i])
        IDLE:   if (sync2_q[i]) state_d[i] = REQ1;
        REQ1:   if (gnt_valid && gnt_idx == IW'(i)) state_d[i] = WAIT_1;
        WAIT_1: if (expire && owner_q == IW'(i))
                  state_d[i] = sync2_q[i] ? PULSE : IDLE;
        PULSE:  state_d[i] = HELD;
        HELD:   if (!sync2_q[i]) state_d[i] = REQ0;
        REQ0:   if (gnt_valid && gnt_idx == IW'(i)) state_d[i] = WAIT_0;
        WAIT_0: if (expire && owner_q == IW'(i))
                  state_d[i] = sync2_q[i] ? HELD : IDLE;
        default: state_d[i] = IDLE;
      endcase
    end

    // Single window per grant: release the owner at expiry instead of wrapping.
    if (expire) begin
      owner_vld_d = 1'b0;
      cnt_d       = '0;
    end else if (owner_vld_q) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (gnt_valid) begin
      owner_vld_d = 1'b1;
      owner_d     = gnt_idx;
      ptr_d       = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      state_q     <= {NCH{IDLE}};
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Outputs are masked by rst so nothing escapes in the reset cycle itself.
  always_comb begin
    sw_out = '0;
    evt_id = '0;
    for (int i = 0; i < NCH; i++)
      if (state_q[i] == PULSE && !rst) sw_out[i] = 1'b1;
    for (int i = 0; i < NCH; i++)
      if (sw_out[i]) evt_id = ($clog2(NCH))'(i);
    evt_valid = |sw_out;
    busy      = owner_vld_q && !rst;
  end

endmodule

// File: tb/tb_shared_debounce_sched.sv
module tb_shared_debounce_sched;

  localparam int NCH   = 4;
  localparam int TBITS = 3;
  localparam int WIN   = 1 << TBITS;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] sw_in = '0;
  logic [NCH-1:0] sw_out;
  logic           evt_valid;
  logic [1:0]     evt_id;
  logic           busy;

  shared_debounce_sched #(.NCH(NCH), .TBITS(TBITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_in     (sw_in),
    .sw_out    (sw_out),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int chks = 0;
  int errs = 0;
  int cyc  = 0;

  // Behavioural model: each channel has a debounced level and a pending flag.
  // A settled channel asks for the timer when its synchronized level differs
  // from the debounced one; at the end of its window the level is adopted if
  // it still differs, and a 0->1 adoption produces one pulse cycle.
  logic [NCH-1:0] ms1 = '0, ms2 = '0;
  logic [NCH-1:0] dl = '0, pend = '0, mpulse = '0;
  int own = -1, left = 0, rr = 0, bfirst = -1;
  int pcnt [NCH];
  int plast [NCH];

  initial for (int i = 0; i < NCH; i++) begin pcnt[i] = 0; plast[i] = -1; end

  always @(posedge clk) begin
    logic [NCH-1:0] s, blk, newp;
    int c, j;
    cyc = cyc + 1;
    if (rst) begin
      ms1 = '0; ms2 = '0; dl = '0; pend = '0; mpulse = '0;
      own = -1; left = 0; rr = 0;
    end else begin
      s = ms2;
      newp = '0;
      for (int i = 0; i < NCH; i++) blk[i] = pend[i] || (own == i) || mpulse[i];
      if (own >= 0) begin
        if (left == 1) begin
          c = own;
          pend[c] = 1'b0;
          if (s[c] != dl[c]) begin
            dl[c] = s[c];
            if (s[c]) newp[c] = 1'b1;
          end
          own = -1;
        end else left = left - 1;
      end else begin
        for (int off = 0; off < NCH; off++) begin
          j = (rr + off) % NCH;
          if (pend[j] && own < 0) begin own = j; left = WIN; rr = (j + 1) % NCH; end
        end
      end
      for (int i = 0; i < NCH; i++) if (!blk[i] && s[i] != dl[i]) pend[i] = 1'b1;
      mpulse = newp;
      ms2 = ms1;
      ms1 = sw_in;
      for (int i = 0; i < NCH; i++) if (mpulse[i]) begin pcnt[i]++; plast[i] = cyc; end
      if (own >= 0 && bfirst < 0) bfirst = cyc;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  // Per-cycle compare against the model, 1 time unit after the edge.
  always @(posedge clk) begin
    logic [NCH-1:0] e_out;
    int e_id;
    #1;
    e_out = rst ? '0 : mpulse;
    e_id = 0;
    for (int i = 0; i < NCH; i++) if (e_out[i]) e_id = i;
    check("sw_out", int'(sw_out), int'(e_out));
    check("evt_valid", int'(evt_valid), int'(|e_out));
    check("evt_id", int'(evt_id), e_id);
    check("busy", int'(busy), (!rst && own >= 0) ? 1 : 0);
  end

  task automatic go_to(input int n);
    while (cyc < n - 1) @(negedge clk);
  endtask

  initial begin
    go_to(3);  rst = 1'b0;

    // single press on ch2, sampled first at edge 10
    go_to(10); sw_in[2] = 1'b1;
    go_to(30);
    check("s1_pulse_cycle", plast[2], 21);
    check("s1_pulse_count", pcnt[2], 1);
    check("s1_busy_first", bfirst, 13);
    sw_in[2] = 1'b0;

    // simultaneous press ch0/ch1 at edge 50
    go_to(50); sw_in[1:0] = 2'b11;
    go_to(80);
    check("s2_ch0_cycle", plast[0], 61);
    check("s2_ch1_cycle", plast[1], 70);
    sw_in[1:0] = 2'b00;

    // glitch on ch3: sampled high at edges 110..112
    go_to(110); sw_in[3] = 1'b1;
    go_to(113); sw_in[3] = 1'b0;
    go_to(135);
    check("s3_no_pulse", pcnt[3], 0);

    // long hold on ch1, ch0 pressed during the hold
    go_to(140); sw_in[1] = 1'b1;
    go_to(160); sw_in[0] = 1'b1;
    go_to(180); sw_in[0] = 1'b0;
    go_to(238);
    check("s4_ch1_cycle", plast[1], 151);
    check("s4_ch1_count", pcnt[1], 2);
    check("s4_ch0_cycle", plast[0], 171);
    check("s4_ch0_count", pcnt[0], 2);

    // release bounce on ch1, then a clean press
    for (int j = 0; j < 10; j++) begin
      go_to(240 + 2 * j);
      sw_in[1] = (j % 2 == 0);
    end
    go_to(260); sw_in[1] = 1'b0;
    go_to(278);
    check("s5_no_second", pcnt[1], 2);
    go_to(280); sw_in[1] = 1'b1;
    go_to(300);
    check("s5_repress_cycle", plast[1], 291);
    check("s5_repress_count", pcnt[1], 3);
    sw_in[1] = 1'b0;

    // reset while ch2 owns the timer in WAIT_1
    go_to(320); sw_in[2] = 1'b1;
    go_to(326); rst = 1'b1; sw_in[2] = 1'b0;
    go_to(327); rst = 1'b0;
    go_to(345);
    check("s6_no_pulse", pcnt[2], 1);
    go_to(350); sw_in[2] = 1'b1;
    go_to(375);
    check("s6_fresh_cycle", plast[2], 361);
    check("s6_fresh_count", pcnt[2], 2);
    sw_in[2] = 1'b0;
    go_to(395);

    $display("Simulation finished: %0d checks, %0d errors", chks, errs);
    $finish;
  end

endmodule
